microprocessor_core: RTL and testbench

- Small load-then-run microprocessor with a 24-bit instruction word: 8-bit opcode, 8-bit field A, 8-bit field B.
- After reset, a program is streamed in on instruction_input, one word per clock, into an internal instruction memory. It then executes from address 0 against a 128-word data memory until it reaches HALT.
- Any data memory cell can be read back at any time through select_mem/output_mem_cell. The block is the top-level compute core of the system.

---
 rtl/microprocessor_core_pkg.sv | 43 ++++
 rtl/microprocessor_alu.sv | 23 ++
 rtl/microprocessor_core.sv | 145 ++++++++++++++
 tb/tb_microprocessor_core.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/microprocessor_core_pkg.sv
// Shared definitions for the load-then-run microprocessor core: widths, opcodes,
// FSM states and instruction field positions.
package microprocessor_core_pkg;

    localparam int DATA_W     = 24;
    localparam int IMEM_DEPTH = 64;
    localparam int DMEM_DEPTH = 128;
    localparam int PC_W       = $clog2(IMEM_DEPTH);
    localparam int DADDR_W    = $clog2(DMEM_DEPTH);

    localparam int OPC_LSB = 16;
    localparam int FA_LSB  = 8;
    localparam int FB_LSB  = 0;

    localparam logic [7:0] OP_HALT  = 8'h00;
    localparam logic [7:0] OP_BEGIN = 8'h01;
    localparam logic [7:0] OP_LDI   = 8'h02;
    localparam logic [7:0] OP_STI   = 8'h04;
    localparam logic [7:0] OP_ADD   = 8'h06;
    localparam logic [7:0] OP_DEC   = 8'h09;
    localparam logic [7:0] OP_MOV   = 8'h0D;
    localparam logic [7:0] OP_BNZ   = 8'h10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [7:0] get_opcode(input logic [DATA_W-1:0] word);
        return word[OPC_LSB +: 8];
    endfunction

    function automatic logic [7:0] get_field_a(input logic [DATA_W-1:0] word);
        return word[FA_LSB +: 8];
    endfunction

    function automatic logic [7:0] get_field_b(input logic [DATA_W-1:0] word);
        return word[FB_LSB +: 8];
    endfunction

endpackage

// File: rtl/microprocessor_alu.sv
// Combinational datapath for the arithmetic/move opcodes; zero reflects the result.
module microprocessor_alu
    import microprocessor_core_pkg::*;
(
    input  logic [7:0]        opcode,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    always_comb begin
        result = op_a;
        case (opcode)
            OP_ADD:  result = op_a + op_b;
            OP_DEC:  result = op_a - DATA_W'(1);
            OP_MOV:  result = op_b;
            default: result = op_a;
        endcase
        zero = (result == '0);
    end

endmodule

// File: rtl/microprocessor_core.sv
// Load-then-run core: streams a program into imem after BEGIN, then executes it
// against dmem until HALT or the end of imem.
//
// state | meaning
// IDLE  | waiting for a BEGIN word on instruction_input
// LOAD  | storing one word per clock into imem until HALT or imem full
// RUN   | executing one instruction per clock from imem[pc]
// DONE  | halted, program_done_flag high, only readback active
module microprocessor_core
    import microprocessor_core_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_W-1:0]    instruction_input,
    input  logic [DADDR_W-1:0]   select_mem,
    output logic [DATA_W-1:0]    output_mem_cell,
    output logic                 program_done_flag
);

    logic [DATA_W-1:0] imem [IMEM_DEPTH];
    logic [DATA_W-1:0] dmem [DMEM_DEPTH];

    state_t             state;
    logic [PC_W-1:0]    load_ptr;
    logic [PC_W-1:0]    pc;
    logic               z_flag;

    logic [DATA_W-1:0]  instr;
    logic [7:0]         op;
    logic [7:0]         field_a;
    logic [7:0]         field_b;
    logic [DADDR_W-1:0] addr_a;
    logic [DADDR_W-1:0] addr_b;
    logic [DATA_W-1:0]  val_a;
    logic [DATA_W-1:0]  val_b;
    logic [DATA_W-1:0]  alu_result;
    logic               alu_zero;

    logic               dmem_we;
    logic [DADDR_W-1:0] dmem_waddr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               unused_field_bits;

    assign instr   = imem[pc];
    assign op      = get_opcode(instr);
    assign field_a = get_field_a(instr);
    assign field_b = get_field_b(instr);
    assign addr_a  = field_a[DADDR_W-1:0];
    assign addr_b  = field_b[DADDR_W-1:0];
    assign val_a   = dmem[addr_a];
    assign val_b   = dmem[addr_b];

    // Bit 7 of data-address fields carries no meaning.
    assign unused_field_bits = field_a[7];

    assign output_mem_cell = dmem[select_mem];

    microprocessor_alu u_alu (
        .opcode (op),
        .op_a   (val_a),
        .op_b   (val_b),
        .result (alu_result),
        .zero   (alu_zero)
    );

    always_comb begin
        dmem_we    = 1'b0;
        dmem_waddr = addr_a;
        dmem_wdata = alu_result;
        if (state == RUN) begin
            case (op)
                OP_LDI: begin
                    dmem_we    = 1'b1;
                    dmem_wdata = {{(DATA_W-8){1'b0}}, field_b};
                end
                OP_STI: begin
                    dmem_we    = 1'b1;
                    dmem_waddr = val_a[DADDR_W-1:0];
                    dmem_wdata = val_b;
                end
                OP_ADD, OP_DEC, OP_MOV: dmem_we = 1'b1;
                default: dmem_we = 1'b0;
            endcase
        end
    end

    // imem holds no reset value; only loaded words are ever fetched.
    always_ff @(posedge clk) begin
        if (state == LOAD)
            imem[load_ptr] <= instruction_input;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DMEM_DEPTH; i++)
                dmem[i] <= '0;
        end else if (dmem_we) begin
            dmem[dmem_waddr] <= dmem_wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= IDLE;
            load_ptr          <= '0;
            pc                <= '0;
            z_flag            <= 1'b0;
            program_done_flag <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (get_opcode(instruction_input) == OP_BEGIN)
                        state <= LOAD;
                end
                LOAD: begin
                    load_ptr <= load_ptr + PC_W'(1);
                    if (get_opcode(instruction_input) == OP_HALT ||
                        load_ptr == PC_W'(IMEM_DEPTH-1)) begin
                        state <= RUN;
                        pc    <= '0;
                    end
                end
                RUN: begin
                    if (op == OP_ADD || op == OP_DEC || op == OP_MOV)
                        z_flag <= alu_zero;
                    if (op == OP_HALT) begin
                        state             <= DONE;
                        program_done_flag <= 1'b1;
                    end else if (op == OP_BNZ && !z_flag) begin
                        // Field A is a signed offset; truncation gives the mod-64 wrap.
                        pc <= pc + field_a[PC_W-1:0];
                    end else if (pc == PC_W'(IMEM_DEPTH-1)) begin
                        state             <= DONE;
                        program_done_flag <= 1'b1;
                    end else begin
                        pc <= pc + PC_W'(1);
                    end
                end
                DONE: program_done_flag <= 1'b1;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_microprocessor_core.sv
// Directed bench for microprocessor_core: loads small programs and checks dmem readback.
module tb_microprocessor_core;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] instruction_input;
    logic [6:0]  select_mem;
    logic [23:0] output_mem_cell;
    logic        program_done_flag;

    int checks = 0;
    int errors = 0;

    microprocessor_core dut (
        .clk               (clk),
        .reset             (reset),
        .instruction_input (instruction_input),
        .select_mem        (select_mem),
        .output_mem_cell   (output_mem_cell),
        .program_done_flag (program_done_flag)
    );

    always #5 clk = ~clk;

    logic [23:0] prog_mul [11] = '{
        24'h010000, 24'h020004, 24'h020105, 24'h060200, 24'h090100,
        24'h0D0301, 24'h10FD00, 24'h02031E, 24'h040302, 24'h000000,
        24'h000000
    };

    logic [23:0] prog_wrap [11] = '{
        24'h010000, 24'h020700, 24'h090700, 24'h100200, 24'h020811,
        24'h020901, 24'h090900, 24'h10FB00, 24'h3F0B0C, 24'h020A22,
        24'h000000
    };

    task automatic check_val(input string tag, input logic [23:0] got, input logic [23:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        @(negedge clk);
        instruction_input = w;
    endtask

    task automatic mem_is(input string tag, input logic [6:0] addr, input logic [23:0] exp);
        select_mem = addr;
        #1;
        check_val(tag, output_mem_cell, exp);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!program_done_flag && n < budget) begin
            @(negedge clk);
            n++;
        end
        check_val(tag, {23'd0, program_done_flag}, 24'd1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        instruction_input = 24'h000000;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic load_mul();
        for (int i = 0; i < 10; i++) send_word(prog_mul[i]);
        send_word(24'h000000);
    endtask

    initial begin
        reset = 1'b0;
        instruction_input = 24'h000000;
        select_mem = 7'd0;
        #12;
        check_val("rst_done", {23'd0, program_done_flag}, 24'd0);
        mem_is("rst_m0", 7'd0, 24'd0);
        mem_is("rst_m127", 7'd127, 24'd0);
        @(negedge clk);
        reset = 1'b1;

        // Garbage before BEGIN, then LDI m5=0xFF; HALT.
        send_word(24'h020677);
        send_word(24'h0000FF);
        send_word(24'h06FFFF);
        mem_is("idle_m6", 7'd6, 24'd0);
        send_word(24'h010000);
        send_word(24'h0205FF);
        send_word(24'h000000);
        wait_done("done_ldi", 20);
        mem_is("ldi_m5", 7'd5, 24'h0000FF);
        mem_is("garbage_m6", 7'd6, 24'd0);

        // Inputs ignored once in DONE.
        send_word(24'h010000);
        send_word(24'h020655);
        send_word(24'h000000);
        repeat (4) @(negedge clk);
        mem_is("done_ignore_m6", 7'd6, 24'd0);
        check_val("done_held", {23'd0, program_done_flag}, 24'd1);

        // Multiply 4x5.
        do_reset();
        check_val("rst2_done", {23'd0, program_done_flag}, 24'd0);
        mem_is("rst2_m5", 7'd5, 24'd0);
        load_mul();
        wait_done("done_mul", 100);
        mem_is("mul_m30", 7'd30, 24'd20);
        mem_is("mul_m1", 7'd1, 24'd0);
        mem_is("mul_m2", 7'd2, 24'd20);
        mem_is("mul_m0", 7'd0, 24'd4);
        mem_is("mul_m3", 7'd3, 24'd30);

        // DEC wrap, BNZ taken/not taken, unknown opcode as NOP.
        do_reset();
        for (int i = 0; i < 11; i++) send_word(prog_wrap[i]);
        send_word(24'h000000);
        wait_done("done_wrap", 100);
        mem_is("dec_wrap_m7", 7'd7, 24'hFFFFFF);
        mem_is("bnz_skip_m8", 7'd8, 24'd0);
        mem_is("dec_zero_m9", 7'd9, 24'd0);
        mem_is("after_nop_m10", 7'd10, 24'h000022);
        mem_is("nop_m11", 7'd11, 24'd0);

        // Full imem without HALT: forced RUN at 64 words, DONE after PC 63.
        do_reset();
        send_word(24'h010000);
        for (int i = 0; i < 64; i++) send_word({16'h020C, 2'b00, 6'(i)});
        send_word(24'h000000);
        wait_done("done_full", 120);
        mem_is("full_m12", 7'd12, 24'h00003F);

        // Reset mid-RUN aborts, reload completes.
        do_reset();
        load_mul();
        repeat (6) @(negedge clk);
        reset = 1'b0;
        #1;
        check_val("abort_done", {23'd0, program_done_flag}, 24'd0);
        mem_is("abort_m0", 7'd0, 24'd0);
        mem_is("abort_m2", 7'd2, 24'd0);
        @(negedge clk);
        reset = 1'b1;
        load_mul();
        wait_done("done_reload", 100);
        mem_is("reload_m30", 7'd30, 24'd20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
